// File: rtl/keypad_event_ctrl.sv
// keypad_event_ctrl: debounces a 16-key matrix and queues coded press/release events in a FIFO.
// Define KEYPAD_REPEAT_EN to add auto-repeat of the lowest-index held key.
module keypad_event_ctrl #(
   parameter int SAMPLE_DIV = 50000,
   parameter int DEB_CNT    = 4,
   parameter int FIFO_DEPTH = 8
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
`endif
) (
   input  logic                          CLK,
   input  logic                          RSTn,
   input  logic [15:0]                   raw_key,
   output logic [15:0]                   key_state,
   output logic                          evt_valid,
   input  logic                          evt_ready,
   output logic [5:0]                    evt_data,
   output logic [$clog2(FIFO_DEPTH):0]   evt_count,
   output logic                          ovf,
   input  logic                          ovf_clr,
   output logic                          irq
);

   localparam int SDW = $clog2(SAMPLE_DIV);
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int CW  = PW + 1;

   logic [SDW-1:0] r_presc;
   logic           w_tick;
   logic [15:0]    r_keyState;
   logic [3:0]     r_cnt [16];
   logic [15:0]    r_pend;
   logic [15:0]    w_toggle;
   logic           w_pendHit;
   logic [3:0]     w_pendIdx;
   logic [15:0]    w_pendClr;
   logic           w_grantValid;
   logic [5:0]     w_pushData;
   logic [5:0]     r_mem [FIFO_DEPTH];
   logic [PW-1:0]  r_wrPtr;
   logic [PW-1:0]  r_rdPtr;
   logic [CW-1:0]  r_count;
   logic [CW-1:0]  w_nextCount;
   logic           w_pop;
   logic           w_full;
   logic           w_push;
   logic           w_drop;
   logic           w_nextOvf;
   logic           r_ovf;
   logic           r_irq;

   assign w_tick = (r_presc == SDW'(SAMPLE_DIV - 1));

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         r_presc <= '0;
      else if (w_tick)
         r_presc <= '0;
      else
         r_presc <= r_presc + SDW'(1);
   end

   always_comb begin
      w_toggle = '0;
      for (int i = 0; i < 16; i++)
         w_toggle[i] = w_tick && (raw_key[i] != r_keyState[i]) && (r_cnt[i] == 4'(DEB_CNT - 1));
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_keyState <= '0;
         for (int i = 0; i < 16; i++)
            r_cnt[i] <= '0;
      end else if (w_tick) begin
         r_keyState <= r_keyState ^ w_toggle;
         for (int i = 0; i < 16; i++) begin
            if (raw_key[i] == r_keyState[i] || w_toggle[i])
               r_cnt[i] <= '0;
            else
               r_cnt[i] <= r_cnt[i] + 4'd1;
         end
      end
   end

`ifdef KEYPAD_REPEAT_EN
   logic        w_anyHeld;
   logic [3:0]  w_heldIdx;
   logic        w_repGrant;
   logic [15:0] r_repCnt;
   logic        r_repFirst;
   logic        r_repPend;

   always_comb begin
      w_anyHeld = 1'b0;
      w_heldIdx = '0;
      for (int i = 0; i < 16; i++) begin
         if (r_keyState[i] && !w_anyHeld) begin
            w_anyHeld = 1'b1;
            w_heldIdx = 4'(i);
         end
      end
   end

   // Any change of the stable key set restarts the delay phase from zero.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         r_repCnt   <= '0;
         r_repFirst <= 1'b1;
         r_repPend  <= 1'b0;
      end else begin
         if (w_repGrant)
            r_repPend <= 1'b0;
         if (w_toggle != '0 || !w_anyHeld) begin
            r_repCnt   <= '0;
            r_repFirst <= 1'b1;
            r_repPend  <= 1'b0;
         end else if (w_tick) begin
            if ((r_repFirst && r_repCnt == 16'(REPEAT_DELAY - 1)) ||
                (!r_repFirst && r_repCnt == 16'(REPEAT_RATE - 1))) begin
               r_repCnt   <= '0;
               r_repFirst <= 1'b0;
               r_repPend  <= 1'b1;
            end else begin
               r_repCnt <= r_repCnt + 16'd1;
            end
         end
      end
   end
`endif

   always_comb begin
      w_pendHit = 1'b0;
      w_pendIdx = '0;
      for (int i = 0; i < 16; i++) begin
         if (r_pend[i] && !w_pendHit) begin
            w_pendHit = 1'b1;
            w_pendIdx = 4'(i);
         end
      end
      w_pendClr = '0;
      if (w_pendHit)
         w_pendClr[w_pendIdx] = 1'b1;
      w_grantValid = w_pendHit;
      w_pushData   = {1'b0, r_keyState[w_pendIdx], w_pendIdx};
`ifdef KEYPAD_REPEAT_EN
      w_repGrant = 1'b0;
      if (!w_pendHit && r_repPend) begin
         w_repGrant   = 1'b1;
         w_grantValid = 1'b1;
         w_pushData   = {2'b11, w_heldIdx};
      end
`endif
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn)
         r_pend <= '0;
      else
         r_pend <= (r_pend & ~w_pendClr) | w_toggle;
   end

   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   always_comb begin
      w_pop     = (r_count != '0) && evt_ready;
      w_full    = (r_count == CW'(FIFO_DEPTH));
      w_push    = w_grantValid && (!w_full || w_pop);
      w_drop    = w_grantValid && w_full && !w_pop;
      w_nextOvf = w_drop || (r_ovf && !ovf_clr);
      case ({w_push, w_pop})
         2'b10:   w_nextCount = r_count + CW'(1);
         2'b01:   w_nextCount = r_count - CW'(1);
         default: w_nextCount = r_count;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            r_mem[i] <= '0;
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_wrPtr] <= w_pushData;
            r_wrPtr        <= r_wrPtr + PW'(1);
         end
         if (w_pop)
            r_rdPtr <= r_rdPtr + PW'(1);
         r_count <= w_nextCount;
         r_ovf   <= w_nextOvf;
         r_irq   <= (w_nextCount != '0) || w_nextOvf;
      end
   end

   assign key_state = r_keyState;
   assign evt_valid = (r_count != '0);
   assign evt_data  = r_mem[r_rdPtr];
   assign evt_count = r_count;
   assign ovf       = r_ovf;
   assign irq       = r_irq;

endmodule
